ram_banco_registros: RTL

// - Register-bank RAM that stores the RTC controller's working image: time, date, timer, command and address bytes.
// - One-hot addressed.
// - Direct consumer of the ROM-to-RAM init FSM.
// - Init writes take data from the ROM. Normal-operation writes take data from the RTC/VGA data bus.
// - Provides a registered read port.
// - Tracks whether a complete 32-location initialisation has finished.

---
 rtl/ram_banco_registros.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ram_banco_registros.sv
// ram_banco_registros: one-hot addressed register bank holding the RTC
// controller's working image (time, date, timer, command, address bytes).
// Loaded by the ROM-to-RAM init FSM (rom_to_ram=1), later written from the
// RTC/VGA data bus. Registered read port with a one-cycle valid pulse, and a
// tracker that reports whether the last init window wrote every location.
//
// Optional build macro: RAM_ONEHOT_CHECK_EN
//   defined   -> multi-hot dir_ram with an enable sets sticky error_dir and
//                the access is suppressed.
//   undefined -> error_dir tied low; multi-hot dir_ram resolves to its
//                lowest set bit.
//
// Init tracker states:
//   state  | meaning
//   REPOSO | idle, no load in progress, init_ok=0
//   CARGA  | init window open, accumulating written-location mask
//   LISTO  | last window wrote all locations, init_ok=1

module ram_banco_registros #(
  parameter int ANCHO_DATO = 8,
  parameter int NUM_REG    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rom_to_ram,
  input  logic [ANCHO_DATO-1:0] rom_data,
  input  logic [ANCHO_DATO-1:0] dato_bus,
  input  logic [NUM_REG-1:0]    dir_ram,
  input  logic                  w_ram_enable,
  input  logic                  r_ram_enable,
  output logic [ANCHO_DATO-1:0] dato_ram,
  output logic                  dato_valido,
  output logic                  init_ok,
  output logic                  error_dir
);

  localparam int IDX_W = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    CARGA  = 2'd1,
    LISTO  = 2'd2
  } estado_t;

  estado_t                estado_q, estado_d;
  logic [NUM_REG-1:0]     wmask_q, wmask_d;
  logic [ANCHO_DATO-1:0]  mem_q [NUM_REG];
  logic [ANCHO_DATO-1:0]  dato_ram_q;
  logic                   dato_valido_q;
  logic                   init_ok_q;

  logic                   dir_zero;
  logic [IDX_W-1:0]       dir_idx;
  logic [NUM_REG-1:0]     dir_low;
  logic                   acc_ok;
  logic                   wr_ok;
  logic                   rd_ok;
  logic [ANCHO_DATO-1:0]  wr_data;
  logic [NUM_REG-1:0]     wr_mask;

  // Address decode: lowest set bit gives both the index and its one-hot mask.
  always_comb begin
    dir_idx = '0;
    dir_low = '0;
    for (int i = NUM_REG - 1; i >= 0; i--) begin
      if (dir_ram[i]) begin
        dir_idx = IDX_W'(i);
        dir_low = NUM_REG'(1) << i;
      end
    end
  end

  assign dir_zero = ~|dir_ram;

`ifdef RAM_ONEHOT_CHECK_EN
  logic dir_multi;
  logic error_dir_q;

  assign dir_multi = |(dir_ram & (dir_ram - NUM_REG'(1)));
  assign acc_ok    = !dir_zero && !dir_multi;

  // Sticky flag for any enabled access with more than one address bit set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_dir_q <= 1'b0;
    end else if ((w_ram_enable || r_ram_enable) && dir_multi) begin
      error_dir_q <= 1'b1;
    end
  end

  assign error_dir = error_dir_q;
`else
  assign acc_ok    = !dir_zero;
  assign error_dir = 1'b0;
`endif

  // A write always wins over a simultaneous read.
  assign wr_ok   = w_ram_enable && acc_ok;
  assign rd_ok   = r_ram_enable && !w_ram_enable && acc_ok;
  assign wr_data = rom_to_ram ? rom_data : dato_bus;
  assign wr_mask = (wr_ok && rom_to_ram) ? dir_low : '0;

  // Storage array; cleared on reset so a partial load never survives it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[dir_idx] <= wr_data;
    end
  end

  // Registered read port: data held between reads, valid pulses one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dato_ram_q    <= '0;
      dato_valido_q <= 1'b0;
    end else begin
      dato_valido_q <= rd_ok;
      if (rd_ok) begin
        dato_ram_q <= mem_q[dir_idx];
      end
    end
  end

  // Init tracker state, written mask and registered init_ok.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q  <= REPOSO;
      wmask_q   <= '0;
      init_ok_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      wmask_q   <= wmask_d;
      init_ok_q <= (estado_d == LISTO);
    end
  end

  // Init tracker next state; the write in the window's first cycle counts.
  always_comb begin
    estado_d = estado_q;
    wmask_d  = wmask_q;
    case (estado_q)
      REPOSO: begin
        if (rom_to_ram) begin
          wmask_d  = wr_mask;
          estado_d = CARGA;
        end
      end
      CARGA: begin
        if (rom_to_ram) begin
          wmask_d = wmask_q | wr_mask;
        end else begin
          estado_d = (&wmask_q) ? LISTO : REPOSO;
        end
      end
      LISTO: begin
        if (rom_to_ram) begin
          wmask_d  = wr_mask;
          estado_d = CARGA;
        end
      end
      default: begin
        estado_d = REPOSO;
        wmask_d  = '0;
      end
    endcase
  end

  assign dato_ram    = dato_ram_q;
  assign dato_valido = dato_valido_q;
  assign init_ok     = init_ok_q;

endmodule
